// File: rtl/dpd_pkg.sv
// Shared constants and state encoding for the DPD digit stream path.
package dpd_pkg;

  localparam int unsigned DPD_W = 10;
  localparam int unsigned BCD_W = 4;

  // Digit index of the held declet; StEmpty means nothing is held.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StD2    = 2'd1,
    StD1    = 2'd2,
    StD0    = 2'd3
  } dpd_state_e;

endpackage

// File: rtl/dpd_unpack.sv
// Combinational densely-packed-decimal declet to three-BCD-digit decoder.
module dpd_unpack
  import dpd_pkg::*;
(
  input  logic [DPD_W-1:0] dpd_i,
  output logic [BCD_W-1:0] d2_o,
  output logic [BCD_W-1:0] d1_o,
  output logic [BCD_W-1:0] d0_o
);

  logic p, q, r, s, t, u, v, w, x, y;

  assign {p, q, r, s, t, u, v, w, x, y} = dpd_i;

  // v selects small/large digit coding; w,x,s,t locate the large digits.
  always_comb begin
    d2_o = {1'b0, p, q, r};
    d1_o = {1'b0, s, t, u};
    d0_o = {1'b0, w, x, y};
    if (v) begin
      unique casez ({w, x, s, t})
        4'b00??: begin
          d0_o = {3'b100, y};
        end
        4'b01??: begin
          d1_o = {3'b100, u};
          d0_o = {1'b0, s, t, y};
        end
        4'b10??: begin
          d2_o = {3'b100, r};
          d0_o = {1'b0, p, q, y};
        end
        4'b1100: begin
          d2_o = {3'b100, r};
          d1_o = {3'b100, u};
          d0_o = {1'b0, p, q, y};
        end
        4'b1101: begin
          d2_o = {3'b100, r};
          d1_o = {1'b0, p, q, u};
          d0_o = {3'b100, y};
        end
        4'b1110: begin
          d1_o = {3'b100, u};
          d0_o = {3'b100, y};
        end
        default: begin
          d2_o = {3'b100, r};
          d1_o = {3'b100, u};
          d0_o = {3'b100, y};
        end
      endcase
    end
  end

endmodule

// File: rtl/dpd_digit_serializer.sv
// Serialises DPD declets into BCD digits, MSD first, with optional
// leading-zero suppression across a multi-declet number.
module dpd_digit_serializer
  import dpd_pkg::*;
#(
  parameter bit ZERO_SUPPRESS = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DPD_W-1:0] in_dpd,
  input  logic             in_first,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [BCD_W-1:0] out_digit,
  output logic             out_first,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready
);

  dpd_state_e       state_q, state_d;
  logic [DPD_W-1:0] dpd_q;
  // first_q doubles as the pending-first flag: set on an in_first accept,
  // cleared once the first surviving digit handshakes.
  logic             first_q, first_d;
  logic             last_q;
  logic             lead_q, lead_d;

  logic [BCD_W-1:0] d2, d1, d0, cur_digit;
  logic             skip, emit, advance, accept;

  dpd_unpack u_unpack (
    .dpd_i (dpd_q),
    .d2_o  (d2),
    .d1_o  (d1),
    .d0_o  (d0)
  );

  // State register and holding registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
      dpd_q   <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      lead_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      lead_q  <= lead_d;
      if (accept) begin
        dpd_q  <= in_dpd;
        last_q <= in_last;
      end
    end
  end

  // Digit mux, skip decision and handshake outputs.
  always_comb begin
    unique case (state_q)
      StD2:    cur_digit = d2;
      StD1:    cur_digit = d1;
      StD0:    cur_digit = d0;
      default: cur_digit = '0;
    endcase
    // The final digit of a number is never skipped, so an all-zero
    // number still yields a single 0.
    skip = ZERO_SUPPRESS && lead_q && (state_q != StEmpty) && (cur_digit == '0) &&
           !((state_q == StD0) && last_q);
    out_valid = (state_q != StEmpty) && !skip;
    emit      = out_valid && out_ready;
    advance   = emit || skip;
    in_ready  = (state_q == StEmpty) || ((state_q == StD0) && advance);
    accept    = in_valid && in_ready;
    out_digit = out_valid ? cur_digit : '0;
    out_first = out_valid && first_q;
    out_last  = out_valid && (state_q == StD0) && last_q;
  end

  // Next state and flag updates; an in_first accept overrides an emit clear.
  always_comb begin
    state_d = state_q;
    first_d = first_q;
    lead_d  = lead_q;
    unique case (state_q)
      StEmpty: if (accept)  state_d = StD2;
      StD2:    if (advance) state_d = StD1;
      StD1:    if (advance) state_d = StD0;
      StD0:    if (advance) state_d = accept ? StD2 : StEmpty;
      default: state_d = StEmpty;
    endcase
    if (emit) begin
      first_d = 1'b0;
      lead_d  = 1'b0;
    end
    if (accept && in_first) begin
      first_d = 1'b1;
      lead_d  = 1'b1;
    end
    if (!ZERO_SUPPRESS) lead_d = 1'b0;
  end

endmodule

// File: tb/tb_dpd_digit_serializer.sv
// Directed bench: one suppressing and one non-suppressing instance.
module tb_dpd_digit_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] in_dpd = '0;
  logic       in_first = 1'b0;
  logic       in_last = 1'b0;
  logic       zs_valid = 1'b0;
  logic       raw_valid = 1'b0;
  logic       out_ready = 1'b1;

  logic       zs_in_ready, zs_first, zs_last, zs_valid_o;
  logic [3:0] zs_digit;
  logic       raw_in_ready, raw_first, raw_last, raw_valid_o;
  logic [3:0] raw_digit;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dpd_digit_serializer #(.ZERO_SUPPRESS(1'b1)) dut_zs (
    .clk       (clk),
    .rst       (rst),
    .in_dpd    (in_dpd),
    .in_first  (in_first),
    .in_last   (in_last),
    .in_valid  (zs_valid),
    .in_ready  (zs_in_ready),
    .out_digit (zs_digit),
    .out_first (zs_first),
    .out_last  (zs_last),
    .out_valid (zs_valid_o),
    .out_ready (out_ready)
  );

  dpd_digit_serializer #(.ZERO_SUPPRESS(1'b0)) dut_raw (
    .clk       (clk),
    .rst       (rst),
    .in_dpd    (in_dpd),
    .in_first  (in_first),
    .in_last   (in_last),
    .in_valid  (raw_valid),
    .in_ready  (raw_in_ready),
    .out_digit (raw_digit),
    .out_first (raw_first),
    .out_last  (raw_last),
    .out_valid (raw_valid_o),
    .out_ready (out_ready)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks one cycle of the suppressing instance: valid, digit, first, last.
  task automatic zs_expect(input string tag, input int v, input int d, input int f, input int l);
    check_eq({tag, " valid"}, int'(zs_valid_o), v);
    check_eq({tag, " digit"}, int'(zs_digit), d);
    check_eq({tag, " first"}, int'(zs_first), f);
    check_eq({tag, " last"}, int'(zs_last), l);
  endtask

  task automatic raw_expect(input string tag, input int v, input int d, input int f, input int l);
    check_eq({tag, " valid"}, int'(raw_valid_o), v);
    check_eq({tag, " digit"}, int'(raw_digit), d);
    check_eq({tag, " first"}, int'(raw_first), f);
    check_eq({tag, " last"}, int'(raw_last), l);
  endtask

  initial begin
    step();
    step();
    rst = 1'b0;

    // Reset state.
    zs_expect("rst", 0, 0, 0, 0);
    check_eq("rst in_ready", int'(zs_in_ready), 1);

    // No suppression: 0A3 -> 1,2,3.
    in_dpd = 10'h0A3; in_first = 1'b1; in_last = 1'b1; raw_valid = 1'b1;
    check_eq("raw0 in_ready", int'(raw_in_ready), 1);
    step();
    raw_valid = 1'b0;
    raw_expect("raw0 d2", 1, 1, 1, 0);
    step();
    raw_expect("raw0 d1", 1, 2, 0, 0);
    step();
    raw_expect("raw0 d0", 1, 3, 0, 1);
    step();
    check_eq("raw0 idle valid", int'(raw_valid_o), 0);

    // No suppression: 000 -> 0,0,0.
    in_dpd = 10'h000; raw_valid = 1'b1;
    step();
    raw_valid = 1'b0;
    raw_expect("raw1 d2", 1, 0, 1, 0);
    step();
    raw_expect("raw1 d1", 1, 0, 0, 0);
    step();
    raw_expect("raw1 d0", 1, 0, 0, 1);
    step();

    // Suppression across declets: 000(first), 007(last) -> single 7.
    in_dpd = 10'h000; in_first = 1'b1; in_last = 1'b0; zs_valid = 1'b1;
    step();
    in_dpd = 10'h007; in_first = 1'b0; in_last = 1'b1;
    zs_expect("sup skip1", 0, 0, 0, 0);
    check_eq("sup skip1 in_ready", int'(zs_in_ready), 0);
    step();
    zs_expect("sup skip2", 0, 0, 0, 0);
    step();
    zs_expect("sup skip3", 0, 0, 0, 0);
    check_eq("sup skip3 in_ready", int'(zs_in_ready), 1);
    step();
    zs_valid = 1'b0;
    zs_expect("sup skip4", 0, 0, 0, 0);
    step();
    zs_expect("sup skip5", 0, 0, 0, 0);
    step();
    zs_expect("sup seven", 1, 7, 1, 1);
    step();
    check_eq("sup idle valid", int'(zs_valid_o), 0);

    // Suppression on an all-zero number: single 0.
    in_dpd = 10'h000; in_first = 1'b1; in_last = 1'b1; zs_valid = 1'b1;
    step();
    zs_valid = 1'b0;
    zs_expect("zero skip1", 0, 0, 0, 0);
    step();
    zs_expect("zero skip2", 0, 0, 0, 0);
    step();
    zs_expect("zero d0", 1, 0, 1, 1);
    step();

    // Back-to-back 0FF, 0A3 with in_valid held.
    in_dpd = 10'h0FF; in_first = 1'b1; in_last = 1'b0; zs_valid = 1'b1;
    step();
    in_dpd = 10'h0A3; in_first = 1'b0; in_last = 1'b1;
    zs_expect("b2b 9a", 1, 9, 1, 0);
    check_eq("b2b 9a in_ready", int'(zs_in_ready), 0);
    step();
    zs_expect("b2b 9b", 1, 9, 0, 0);
    check_eq("b2b 9b in_ready", int'(zs_in_ready), 0);
    step();
    zs_expect("b2b 9c", 1, 9, 0, 0);
    check_eq("b2b 9c in_ready", int'(zs_in_ready), 1);
    step();
    zs_valid = 1'b0;
    zs_expect("b2b 1", 1, 1, 0, 0);
    step();
    zs_expect("b2b 2", 1, 2, 0, 0);
    step();
    zs_expect("b2b 3", 1, 3, 0, 1);
    step();
    check_eq("b2b idle valid", int'(zs_valid_o), 0);

    // Backpressure on digit 2 of 0A3.
    in_dpd = 10'h0A3; in_first = 1'b1; in_last = 1'b1; zs_valid = 1'b1;
    step();
    zs_valid = 1'b0;
    zs_expect("bp 1", 1, 1, 1, 0);
    step();
    out_ready = 1'b0;
    zs_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      zs_expect("bp hold", 1, 2, 0, 0);
      check_eq("bp hold in_ready", int'(zs_in_ready), 0);
      step();
    end
    zs_valid = 1'b0;
    out_ready = 1'b1;
    zs_expect("bp 2", 1, 2, 0, 0);
    step();
    zs_expect("bp 3", 1, 3, 0, 1);
    step();

    // Reset while in D1 discards the held declet.
    in_dpd = 10'h0FF; in_first = 1'b1; in_last = 1'b1; zs_valid = 1'b1;
    step();
    zs_valid = 1'b0;
    zs_expect("rmid 9", 1, 9, 1, 0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    zs_expect("rmid post", 0, 0, 0, 0);
    check_eq("rmid in_ready", int'(zs_in_ready), 1);
    zs_valid = 1'b1;
    step();
    zs_valid = 1'b0;
    zs_expect("rmid new 9a", 1, 9, 1, 0);
    step();
    zs_expect("rmid new 9b", 1, 9, 0, 0);
    step();
    zs_expect("rmid new 9c", 1, 9, 0, 1);
    step();
    check_eq("rmid idle valid", int'(zs_valid_o), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
